// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined immediate extender with a valid/ready handshake.
// The immediate is extended combinationally at the input and stored already
// extended in a main register (drives out_*) backed by one skid register, so
// in_ready depends on registered state only.
// Optional feature: define EXT_COUNT_EN to add the saturating xfer_count port.
module imm_ext_pipe #(
   parameter int unsigned IN_W    = 16,
   parameter int unsigned OUT_W   = 32,
   parameter int unsigned SHIFT_B = 2,
   parameter int unsigned TAG_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [2:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
`ifdef EXT_COUNT_EN
   ,
   output logic [15:0]      xfer_count
`endif
);

   typedef enum logic [2:0] {
      MODE_ZERO   = 3'd0,
      MODE_SIGN   = 3'd1,
      MODE_INST   = 3'd2,
      MODE_UPPER  = 3'd3,
      MODE_BRANCH = 3'd4
   } mode_e;

   logic [OUT_W-1:0] ext;
   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] skid_data;
   logic [TAG_W-1:0] skid_tag;
   logic             skid_valid;
   logic             accept;
   logic             pop;

   assign in_ready = !skid_valid;
   assign accept   = in_valid & in_ready & !flush;
   assign pop      = out_valid & out_ready & !flush;

   // Extend the incoming immediate according to its mode (codes 5-7 act as ZERO).
   always_comb begin
      sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
      ext  = {{(OUT_W-IN_W){1'b0}}, in_imm};
      case (mode_e'(in_mode))
         MODE_SIGN:   ext = sext;
         MODE_INST:   ext = '0;
         MODE_UPPER:  ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
         MODE_BRANCH: ext = sext << SHIFT_B;
         default:     ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
      endcase
   end

   // Main/skid storage: refill main from skid first, otherwise from the input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_tag    <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_tag   <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!out_valid || pop) begin
         if (skid_valid) begin
            // in_ready is low whenever skid holds a word, so no accept can collide here
            out_data   <= skid_data;
            out_tag    <= skid_tag;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else if (accept) begin
            out_data  <= ext;
            out_tag   <= in_tag;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_data  <= ext;
         skid_tag   <= in_tag;
         skid_valid <= 1'b1;
      end
   end

`ifdef EXT_COUNT_EN
   // Count completed output transfers, saturating; only rst clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xfer_count <= '0;
      end else if (pop && (xfer_count != 16'hFFFF)) begin
         xfer_count <= xfer_count + 16'd1;
      end
   end
`endif

endmodule
